aes_inv_cipher_iter: RTL and testbench

Iterative AES-128 decryption core. It runs one inverse round every two clock cycles, using a registered inverse-S-box lookup stage followed by a key-add/InvMixColumns stage. It accepts a 128-bit ciphertext over a valid/ready handshake and reads round keys from an external key store by index. It returns the plaintext over a second valid/ready handshake, and is the receive-side counterpart of the encryption round datapath.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_inv_cipher_iter_if.sv | 25 ++
 rtl/aes_inv_cipher_iter_inv_s4.sv | 42 ++++
 rtl/aes_inv_cipher_iter.sv | 106 ++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher.
// Holds the FSM state type, the round count and the GF(2^8) helpers
// used by the InvShiftRows / InvMixColumns datapath.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} fsm_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product; with a constant k it folds to an xor network.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // One column, row 0 in [31:24].
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Byte n = row n%4, column n/4, byte 0 in [127:120]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and key-store bundle for aes_inv_cipher_iter.
//   in_valid/in_ready/in_data    : ciphertext input handshake
//   rk_idx/rk                    : combinational round-key store lookup
//   out_valid/out_ready/out_data : plaintext output handshake
// master = producer/consumer/key-store side, slave = the core.
interface aes_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_cipher_iter_inv_s4.sv
// Four parallel inverse S-box ROMs with a registered 32-bit output.
//   clk, rst : clock, async active-high reset (clears dout)
//   en       : load enable for the output register
//   din      : four input bytes
//   dout     : InvSubBytes(din), one cycle later
module inv_s4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= {INV_SBOX[din[31:24]], INV_SBOX[din[23:16]],
               INV_SBOX[din[15:8]],  INV_SBOX[din[7:0]]};
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one inverse round per SUB/MIX pair.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of aes_inv_cipher_iter_if (ciphertext in,
//              round-key index out / key in, plaintext out)
// Accept in IDLE adds rk[10]; SUB registers InvSubBytes(InvShiftRows(state));
// MIX adds rk[round] and applies InvMixColumns except on the last round.
module aes_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input logic                  clk,
  input logic                  rst,
  aes_inv_cipher_iter_if.slave bus
);
  import aes_pkg::*;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q;
  logic [127:0] st_q;
  logic [127:0] sr;
  logic [127:0] sub_q;
  logic [127:0] t;
  logic [127:0] mixed;
  logic         sub_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (bus.in_valid) fsm_d = SUB;
      SUB:     fsm_d = MIX;
      MIX:     fsm_d = (round_q == '0) ? DONE : SUB;
      DONE:    if (bus.out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_idx    = round_q;
    sub_en        = 1'b0;
    case (fsm_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.rk_idx   = 4'(NR);
      end
      SUB:  sub_en = 1'b1;
      MIX:  ;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.rk_idx    = '0;
      end
      default: ;
    endcase
  end

  assign sr           = inv_shift_rows(st_q);
  assign t            = sub_q ^ bus.rk;
  assign bus.out_data = st_q;

  // One S-box quad per column after the row rotation.
  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_s4 u_s4 (
      .clk  (clk),
      .rst  (rst),
      .en   (sub_en),
      .din  (sr[127 - 32*c -: 32]),
      .dout (sub_q[127 - 32*c -: 32])
    );
  end

  always_comb begin
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = inv_mix_column(t[127 - 32*c -: 32]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= '0;
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (bus.in_valid) begin
          st_q    <= bus.in_data ^ bus.rk;
          round_q <= 4'(NR - 1);
        end
        MIX: begin
          if (round_q != '0) begin
            st_q    <= mixed;
            round_q <= round_q - 4'd1;
          end else begin
            st_q <= t;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: a byte-matrix AES-128
// reference plus a per-cycle timing/handshake model, driven by directed
// FIPS-197 vectors and a random back-to-back run.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_cipher_iter_if bus ();

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_tab [11];
  logic [127:0] cur_key;
  logic [3:0]   rk_seq [$];

  assign bus.rk = (bus.rk_idx <= 4'd10) ? rk_tab[bus.rk_idx] : '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from the field inverse and the affine map; inverse table by inversion.
  task automatic init_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [7:0]   m [4][4];
    logic [7:0]   n [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] k;
    logic [127:0] v;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    v = ct ^ round_key(key, 10);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = v[127 - 8*(4*c + r) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) n[r][(c + r) % 4] = m[r][c];
      k = round_key(key, rnd);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          n[r][c] = isbox[n[r][c]] ^ k[127 - 8*(4*c + r) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - i + 4) % 4], n[j][c]);
            m[i][c] = acc;
          end
      end else begin
        m = n;
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) v[127 - 8*(4*c + r) -: 8] = m[r][c];
    return v;
  endfunction

  task automatic load_key(input logic [127:0] key);
    cur_key = key;
    for (int r = 0; r < 11; r++) rk_tab[r] = round_key(key, r);
  endtask

  // ---------------- per-cycle compare process ----------------
  int           phase    = 0;
  int           last_acc = -1000;
  logic [127:0] exp_pt   = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_out_data",  bus.out_data,        128'(0));
      chk("rst_rk_idx",    128'(bus.rk_idx),    128'(10));
      phase    = 0;
      last_acc = -1000;
    end else if (phase == 0) begin
      chk("idle_in_ready",  128'(bus.in_ready),  128'(1));
      chk("idle_out_valid", 128'(bus.out_valid), 128'(0));
      chk("idle_rk_idx",    128'(bus.rk_idx),    128'(10));
      if (bus.in_valid) begin
        exp_pt = model_dec(cur_key, bus.in_data);
        chk("accept_spacing", 128'((cyc - last_acc) >= 22), 128'(1));
        last_acc = cyc;
        phase    = 1;
      end
    end else if (phase <= 20) begin
      chk("busy_in_ready",  128'(bus.in_ready),  128'(0));
      chk("busy_out_valid", 128'(bus.out_valid), 128'(0));
      chk("busy_rk_idx",    128'(bus.rk_idx),    128'(9 - (phase - 1) / 2));
      phase++;
    end else begin
      chk("done_out_valid", 128'(bus.out_valid), 128'(1));
      chk("done_in_ready",  128'(bus.in_ready),  128'(0));
      chk("done_rk_idx",    128'(bus.rk_idx),    128'(0));
      chk("done_out_data",  bus.out_data,        exp_pt);
      if (bus.out_ready) begin
        phase = 0;
        done_cnt++;
      end else begin
        phase++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends one time unit after a rising edge; ends in cycle T+1.
  task automatic send(input logic [127:0] key, input logic [127:0] ct);
    int n;
    n = 0;
    load_key(key);
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    rk_seq.delete();
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_seen", 128'(bus.in_ready), 128'(1));
    rk_seq.push_back(bus.rk_idx);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Ends on the falling edge where out_valid is first seen.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid) rk_seq.push_back(bus.rk_idx);
    end while (!bus.out_valid && lat < 100);
    chk("out_valid_seen", 128'(bus.out_valid), 128'(1));
  endtask

  task automatic recv();
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_done++;
  endtask

  int   lat;
  int   n;
  int   exp_seq [21];
  logic [127:0] first;
  logic [127:0] rkey;
  logic [127:0] rct;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    exp_seq = '{10, 9, 9, 8, 8, 7, 7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};
    init_tables();
    load_key(K1);

    chk("model_sbox_53", 128'(sbox[8'h53]), 128'(8'hed));
    chk("model_c1",      model_dec(K1, C1), P1);
    chk("model_appb",    model_dec(K2, C2), P2);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // FIPS-197 C.1 with latency
    send(K1, C1);
    wait_out(lat);
    chk("c1_latency", 128'(lat), 128'(21));
    chk("c1_pt",      bus.out_data, P1);
    recv();
    @(negedge clk);
    chk("c1_in_ready_after", 128'(bus.in_ready), 128'(1));
    tick();

    // FIPS-197 App. B with round-key index sequence
    send(K2, C2);
    wait_out(lat);
    chk("appb_pt",      bus.out_data, P2);
    chk("appb_rk_size", 128'(rk_seq.size()), 128'(21));
    for (int i = 0; i < 21 && i < rk_seq.size(); i++)
      chk("appb_rk_seq", 128'(rk_seq[i]), 128'(exp_seq[i]));
    recv();

    // Backpressure for 50 cycles
    send(K1, C1);
    wait_out(lat);
    first = bus.out_data;
    repeat (50) begin
      @(negedge clk);
      chk("bp_out_data", bus.out_data, first);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    chk("bp_pt", first, P1);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    chk("bp_in_ready_after",  128'(bus.in_ready),  128'(1));
    chk("bp_out_valid_after", 128'(bus.out_valid), 128'(0));
    tick();

    // Garbage in_valid pulses while busy
    send(K2, C2);
    repeat (2) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("busy_pt", bus.out_data, P2);
    recv();

    // in_valid together with out_ready in DONE: accept one cycle later
    send(K1, C1);
    wait_out(lat);
    tick();
    bus.in_valid  = 1'b1;
    bus.in_data   = C1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    chk("ov_in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("ov_latency", 128'(lat), 128'(21));
    chk("ov_pt",      bus.out_data, P1);
    recv();

    // Reset in cycle T+7, then a clean C.1
    send(K2, C2);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mr_in_ready",  128'(bus.in_ready),  128'(1));
    tick();
    rst = 1'b0;
    repeat (2) tick();
    send(K1, C1);
    wait_out(lat);
    chk("mr_c1_latency", 128'(lat), 128'(21));
    chk("mr_c1_pt",      bus.out_data, P1);
    recv();

    // Random back-to-back with random out_ready
    for (int i = 0; i < 100; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rct  = {$urandom, $urandom, $urandom, $urandom};
      send(rkey, rct);
      bus.out_ready = 1'($urandom_range(0, 1));
      n = 0;
      forever begin
        @(negedge clk);
        if ((bus.out_valid && bus.out_ready) || n >= 300) break;
        n++;
        tick();
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      chk("rand_transfer", 128'(bus.out_valid && bus.out_ready), 128'(1));
      tick();
      bus.out_ready = 1'b0;
      exp_done++;
    end

    repeat (2) tick();
    chk("done_count", 128'(done_cnt), 128'(exp_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
